regfile_wr_arbiter: RTL and testbench
=====================================

REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the write data path.
REQ-002 SHALL have parameter PC_IDX, default 4'b1111, register index treated as the PC.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port alu_req  input  1  ALU writeback request, level, held until granted.
REQ-006 SHALL have port alu_rd  input  4  ALU destination register index.
REQ-007 SHALL have port alu_data  input  DATA_W  ALU writeback data.
REQ-008 SHALL have port alu_gnt  output  1  one-cycle grant to ALU, combinational.
REQ-009 SHALL have port mem_req, mem_rd, mem_data, mem_gnt, identical to the ALU ports, for load writeback.
REQ-010 SHALL have port wr_en  output  1  registered register-file write enable; also the decoder enable.
REQ-011 SHALL have port wr_sel  output  4  registered destination index; also the decoder input.
REQ-012 SHALL have port wr_data  output  DATA_W  registered write data.
REQ-013 SHALL have port wr_onehot  output  16  one-hot decode of wr_sel gated by wr_en.
REQ-014 SHALL have port pc_wr  output  1  registered; high with wr_en when wr_sel == PC_IDX.

Function
REQ-015 SHALL implement FSM states IDLE and FLUSH.
REQ-016 In IDLE, with exactly one req high, SHALL assert that requester's gnt in the same cycle.
REQ-017 In IDLE, with both req high, SHALL grant the requester not granted most recently (round-robin via 1-bit last_gnt).
REQ-018 SHALL never assert alu_gnt and mem_gnt in the same cycle.
REQ-019 On a grant, SHALL register the granted rd/data into wr_sel/wr_data and set wr_en=1 the following cycle (latency 1).
REQ-020 With no grant in a cycle, SHALL drive wr_en=0 the following cycle, holding wr_sel/wr_data at their previous values.
REQ-021 On a grant whose rd == PC_IDX, SHALL set pc_wr=1 alongside wr_en and move IDLE -> FLUSH.
REQ-022 In FLUSH, SHALL issue no grants for exactly one cycle, then return to IDLE.
REQ-023 Pending requests during FLUSH SHALL be held by the requester; arbitration resumes in IDLE with last_gnt unchanged by FLUSH.
REQ-024 Same-index requests from both sources in one cycle SHALL be serialised by round-robin, in consecutive writes, with no merging.
REQ-025 wr_onehot SHALL equal (1 << wr_sel) when wr_en=1, else 16'h0000.
REQ-026 Requests with req=0 SHALL be ignored regardless of rd/data values.

Reset
REQ-027 While rst=1 SHALL force state=IDLE, last_gnt=MEM (so ALU wins the first tie), wr_en=0, pc_wr=0, wr_sel=4'h0, wr_data=0, wr_onehot=0, gnts=0.
REQ-028 rst asserted during FLUSH or with a write in flight SHALL discard it: no wr_en pulse in the cycle after rst.

Structure
REQ-029 The shared package SHALL hold the FSM state encoding (IDLE, FLUSH), the requester ID constants (REQ_ALU, REQ_MEM) and the PC index constant.
REQ-030 The one-hot decode SHALL be an instance of the existing decoder_4x16 sub-module (Y=wr_onehot, I=wr_sel, enable=wr_en); no other sub-modules.

Verification
REQ-031 alu_req=1, alu_rd=3, alu_data=32'hDEADBEEF alone -> alu_gnt=1 same cycle; next cycle wr_en=1, wr_sel=3, wr_onehot=16'h0008, pc_wr=0.
REQ-032 Both req held from reset, alu_rd=1, mem_rd=2 -> gnt order ALU, MEM, ALU, MEM on consecutive cycles; wr_sel sequence 1,2,1,2.
REQ-033 mem_req with mem_rd=15, then alu_req rd=5 next cycle -> write to R15 with pc_wr=1; one cycle with both gnts=0; ALU granted the cycle after; wr_onehot 16'h8000 then 16'h0000 then 16'h0020.
REQ-034 Both req with rd=7, data A (ALU) and B (MEM) -> two consecutive writes to R7, A then B, wr_onehot=16'h0080 both cycles.
REQ-035 rst=1 asserted in the cycle of a grant -> next cycle wr_en=0, wr_onehot=0, state IDLE; after release first tie goes to ALU.
REQ-036 Sweep each rd 0..15 via ALU -> wr_onehot equals 1<<rd for each, pc_wr high only for rd=15, followed by one no-grant cycle.

Source files
------------

// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter:
// FSM encoding, requester identifiers and the default PC register index.
package regfile_wr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   // Identity of the most recently granted requester, kept in last_gnt
   localparam logic REQ_ALU = 1'b0;
   localparam logic REQ_MEM = 1'b1;

   localparam logic [3:0] PC_IDX_DEFAULT = 4'b1111;

   function automatic logic is_pc(input logic [3:0] rd, input logic [3:0] pc_idx);
      return rd == pc_idx;
   endfunction

endpackage

// File: rtl/regfile_wr_arbiter_decoder.sv
// 4-to-16 one-hot decoder with an enable; all outputs low when disabled.
module decoder_4x16 (
   input  logic [3:0]  i,
   input  logic        enable,
   output logic [15:0] y
);

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_dec
         assign y[gi] = enable && (i == 4'(gi));
      end
   endgenerate

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Two-source (ALU / load) register-file write-port arbiter with round-robin
// tie-break and a one-cycle grant blackout after any write to the PC.
module regfile_wr_arbiter
   import regfile_wr_arbiter_pkg::*;
#(
   parameter int         DATA_W = 32,
   parameter logic [3:0] PC_IDX = PC_IDX_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_req,
   input  logic [3:0]        alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   output logic              alu_gnt,
   input  logic              mem_req,
   input  logic [3:0]        mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output logic              mem_gnt,
   output logic              wr_en,
   output logic [3:0]        wr_sel,
   output logic [DATA_W-1:0] wr_data,
   output logic [15:0]       wr_onehot,
   output logic              pc_wr
);

   state_t            state_reg;
   logic              last_gnt_reg;
   logic              wr_en_reg;
   logic              pc_wr_reg;
   logic [3:0]        wr_sel_reg;
   logic [DATA_W-1:0] wr_data_reg;

   logic              grant_any;
   logic [3:0]        grant_rd;
   logic [DATA_W-1:0] grant_data;
   logic              grant_pc;

   // Grants are combinational; the requester not served last wins a tie
   always_comb begin
      alu_gnt = 1'b0;
      mem_gnt = 1'b0;
      if (!rst && state_reg == IDLE) begin
         if (alu_req && mem_req) begin
            alu_gnt = (last_gnt_reg == REQ_MEM);
            mem_gnt = (last_gnt_reg == REQ_ALU);
         end else begin
            alu_gnt = alu_req;
            mem_gnt = mem_req;
         end
      end
   end

   assign grant_any  = alu_gnt | mem_gnt;
   assign grant_rd   = alu_gnt ? alu_rd : mem_rd;
   assign grant_data = alu_gnt ? alu_data : mem_data;
   assign grant_pc   = grant_any && is_pc(grant_rd, PC_IDX);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         last_gnt_reg <= REQ_MEM;
         wr_en_reg    <= 1'b0;
         pc_wr_reg    <= 1'b0;
         wr_sel_reg   <= 4'h0;
         wr_data_reg  <= '0;
      end else begin
         wr_en_reg <= grant_any;
         pc_wr_reg <= grant_pc;
         if (grant_any) begin
            wr_sel_reg   <= grant_rd;
            wr_data_reg  <= grant_data;
            last_gnt_reg <= alu_gnt ? REQ_ALU : REQ_MEM;
         end
         case (state_reg)
            IDLE:    if (grant_pc) state_reg <= FLUSH;
            FLUSH:   state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign wr_en   = wr_en_reg;
   assign wr_sel  = wr_sel_reg;
   assign wr_data = wr_data_reg;
   assign pc_wr   = pc_wr_reg;

   decoder_4x16 u_dec (
      .i      (wr_sel_reg),
      .enable (wr_en_reg),
      .y      (wr_onehot)
   );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed vector table for the documented scenarios, then randomized
// held-request traffic checked against a transaction-level arbiter model.
module tb_regfile_wr_arbiter;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          alu_req, mem_req;
   logic [3:0]    alu_rd, mem_rd;
   logic [DW-1:0] alu_data, mem_data;
   logic          alu_gnt, mem_gnt;
   logic          wr_en, pc_wr;
   logic [3:0]    wr_sel;
   logic [DW-1:0] wr_data;
   logic [15:0]   wr_onehot;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   regfile_wr_arbiter #(.DATA_W(DW), .PC_IDX(4'b1111)) dut (
      .clk       (clk),
      .rst       (rst),
      .alu_req   (alu_req),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_gnt   (alu_gnt),
      .mem_req   (mem_req),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .mem_gnt   (mem_gnt),
      .wr_en     (wr_en),
      .wr_sel    (wr_sel),
      .wr_data   (wr_data),
      .wr_onehot (wr_onehot),
      .pc_wr     (pc_wr)
   );

   typedef struct {
      string       tag;
      logic        rst;
      logic        ar;
      logic [3:0]  ard;
      logic [31:0] ad;
      logic        mr;
      logic [3:0]  mrd;
      logic [31:0] md;
      logic        eag;
      logic        emg;
      logic        ewe;
      logic [3:0]  esel;
      logic [31:0] ewd;
      logic [15:0] eoh;
      logic        epc;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [15:0] onehot_of(input logic en, input logic [3:0] sel);
      logic [15:0] one;
      one = 16'h0001;
      return en ? (one << sel) : 16'h0000;
   endfunction

   function automatic void add(input string tag, input logic r,
                               input logic ar, input logic [3:0] ard, input logic [31:0] ad,
                               input logic mr, input logic [3:0] mrd, input logic [31:0] md,
                               input logic eag, input logic emg, input logic ewe,
                               input logic [3:0] esel, input logic [31:0] ewd, input logic epc);
      vec_t v;
      v.tag = tag; v.rst = r;
      v.ar = ar; v.ard = ard; v.ad = ad;
      v.mr = mr; v.mrd = mrd; v.md = md;
      v.eag = eag; v.emg = emg; v.ewe = ewe;
      v.esel = esel; v.ewd = ewd; v.epc = epc;
      v.eoh = onehot_of(ewe, esel);
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   task automatic drive(input logic r, input logic ar, input logic [3:0] ard, input logic [31:0] ad,
                        input logic mr, input logic [3:0] mrd, input logic [31:0] md);
      rst = r;
      alu_req = ar; alu_rd = ard; alu_data = ad;
      mem_req = mr; mem_rd = mrd; mem_data = md;
   endtask

   // Inputs applied 1ns after a rising edge; grants checked 1ns later,
   // registered outputs checked 1ns after the following rising edge.
   task automatic run_row(input vec_t v);
      drive(v.rst, v.ar, v.ard, v.ad, v.mr, v.mrd, v.md);
      #1;
      chk({v.tag, ".alu_gnt"}, 32'(alu_gnt), 32'(v.eag));
      chk({v.tag, ".mem_gnt"}, 32'(mem_gnt), 32'(v.emg));
      @(posedge clk);
      #1;
      chk({v.tag, ".wr_en"},     32'(wr_en),     32'(v.ewe));
      chk({v.tag, ".wr_sel"},    32'(wr_sel),    32'(v.esel));
      chk({v.tag, ".wr_data"},   wr_data,        v.ewd);
      chk({v.tag, ".wr_onehot"}, 32'(wr_onehot), 32'(v.eoh));
      chk({v.tag, ".pc_wr"},     32'(pc_wr),     32'(v.epc));
      $display("vec %-8s gnt=%b%b wr_en=%b sel=%0d data=%h oh=%h pc=%b",
               v.tag, alu_gnt, mem_gnt, wr_en, wr_sel, wr_data, wr_onehot, pc_wr);
   endtask

   // Random-phase reference model state
   logic        pa, pm;
   logic [3:0]  pa_rd, pm_rd;
   logic [31:0] pa_d, pm_d;
   int          blackout;
   logic        alu_turn;
   logic        m_we, m_pc;
   logic [3:0]  m_sel;
   logic [31:0] m_wd;

   initial begin
      drive(1'b1, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0, 32'h0);
      @(posedge clk);
      #1;

      //  tag       rst ar rd  data          mr rd  data          ag mg we sel data          pc
      add("reset",  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0);
      add("r031",   0, 1, 3, 32'hDEADBEEF, 0, 0, 32'h0,        1, 0, 1, 3, 32'hDEADBEEF, 0);
      add("idle",   0, 0, 9, 32'h12345678, 0, 4, 32'h87654321, 0, 0, 0, 3, 32'hDEADBEEF, 0);
      add("rst32",  1, 1, 1, 32'h11,       1, 2, 32'h22,       0, 0, 0, 0, 32'h0,        0);
      add("r032a",  0, 1, 1, 32'h11,       1, 2, 32'h22,       1, 0, 1, 1, 32'h11,       0);
      add("r032b",  0, 1, 1, 32'h11,       1, 2, 32'h22,       0, 1, 1, 2, 32'h22,       0);
      add("r032c",  0, 1, 1, 32'h11,       1, 2, 32'h22,       1, 0, 1, 1, 32'h11,       0);
      add("r032d",  0, 1, 1, 32'h11,       1, 2, 32'h22,       0, 1, 1, 2, 32'h22,       0);
      add("r033a",  0, 0, 0, 32'h0,        1, 15, 32'hF0,      0, 1, 1, 15, 32'hF0,      1);
      add("r033b",  0, 1, 5, 32'h55,       0, 0, 32'h0,        0, 0, 0, 15, 32'hF0,      0);
      add("r033c",  0, 1, 5, 32'h55,       0, 0, 32'h0,        1, 0, 1, 5, 32'h55,       0);
      add("rst34",  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0);
      add("r034a",  0, 1, 7, 32'hAAAA,     1, 7, 32'hBBBB,     1, 0, 1, 7, 32'hAAAA,     0);
      add("r034b",  0, 0, 7, 32'hAAAA,     1, 7, 32'hBBBB,     0, 1, 1, 7, 32'hBBBB,     0);
      add("r035a",  0, 1, 9, 32'h99,       0, 0, 32'h0,        1, 0, 1, 9, 32'h99,       0);
      add("r035b",  1, 1, 4, 32'h44,       1, 6, 32'h66,       0, 0, 0, 0, 32'h0,        0);
      add("r035c",  0, 1, 4, 32'h44,       1, 6, 32'h66,       1, 0, 1, 4, 32'h44,       0);
      add("r035d",  0, 0, 4, 32'h44,       1, 6, 32'h66,       0, 1, 1, 6, 32'h66,       0);
      add("r028a",  0, 0, 0, 32'h0,        1, 15, 32'hFF,      0, 1, 1, 15, 32'hFF,      1);
      add("r028b",  1, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0);
      add("r028c",  0, 1, 4, 32'h44,       1, 6, 32'h66,       1, 0, 1, 4, 32'h44,       0);
      add("idle2",  0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 4, 32'h44,       0);
      for (int r = 0; r < 16; r++) begin
         add($sformatf("sw%0d", r), 0, 1, 4'(r), 32'(r) * 32'h01010101, 0, 0, 32'h0,
             1, 0, 1, 4'(r), 32'(r) * 32'h01010101, (r == 15));
      end
      add("swfl",   0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 15, 32'h0F0F0F0F, 0);
      add("swpost", 0, 1, 0, 32'h0,        0, 0, 32'h0,        1, 0, 1, 0, 32'h0,        0);
      add("idle3",  0, 0, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 0, 32'h0,        0);

      foreach (vecs[k]) run_row(vecs[k]);

      // Randomized traffic: each source holds its request until served
      pa = 1'b0; pm = 1'b0;
      pa_rd = '0; pm_rd = '0; pa_d = '0; pm_d = '0;
      blackout = 0; alu_turn = 1'b1;
      m_we = 1'b0; m_pc = 1'b0; m_sel = '0; m_wd = '0;
      for (int i = 0; i < 400; i++) begin
         logic r, ga, gm;
         logic [3:0] wrd;
         r = (i == 0) || ($urandom_range(0, 39) == 0);
         if (!pa && $urandom_range(0, 2) == 0) begin
            pa = 1'b1;
            pa_rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            pa_d = $urandom;
         end
         if (!pm && $urandom_range(0, 2) == 0) begin
            pm = 1'b1;
            pm_rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            pm_d = $urandom;
         end
         drive(r, pa, pa ? pa_rd : 4'($urandom_range(0, 15)), pa ? pa_d : $urandom,
                  pm, pm ? pm_rd : 4'($urandom_range(0, 15)), pm ? pm_d : $urandom);

         ga = 1'b0; gm = 1'b0;
         if (!r && blackout == 0) begin
            if (pa && pm) begin
               ga = alu_turn;
               gm = !alu_turn;
            end else begin
               ga = pa;
               gm = pm;
            end
         end
         #1;
         chk($sformatf("rnd%0d.alu_gnt", i), 32'(alu_gnt), 32'(ga));
         chk($sformatf("rnd%0d.mem_gnt", i), 32'(mem_gnt), 32'(gm));

         if (r) begin
            m_we = 1'b0; m_pc = 1'b0; m_sel = '0; m_wd = '0;
            blackout = 0; alu_turn = 1'b1;
         end else if (ga || gm) begin
            wrd = ga ? pa_rd : pm_rd;
            m_we = 1'b1;
            m_sel = wrd;
            m_wd = ga ? pa_d : pm_d;
            m_pc = (wrd == 4'hF);
            blackout = m_pc ? 1 : 0;
            alu_turn = gm;
            if (ga) pa = 1'b0;
            else    pm = 1'b0;
         end else begin
            m_we = 1'b0;
            m_pc = 1'b0;
            blackout = 0;
         end

         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d.wr_en", i),     32'(wr_en),     32'(m_we));
         chk($sformatf("rnd%0d.wr_sel", i),    32'(wr_sel),    32'(m_sel));
         chk($sformatf("rnd%0d.wr_data", i),   wr_data,        m_wd);
         chk($sformatf("rnd%0d.wr_onehot", i), 32'(wr_onehot), 32'(onehot_of(m_we, m_sel)));
         chk($sformatf("rnd%0d.pc_wr", i),     32'(pc_wr),     32'(m_pc));
         $display("rnd %0d rst=%b req=%b%b gnt=%b%b wr_en=%b sel=%0d data=%h pc=%b",
                  i, r, alu_req, mem_req, ga, gm, wr_en, wr_sel, wr_data, pc_wr);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
